fft_step1_feeder: RTL and testbench

Front-end feeder for the stage-1 butterfly. It accepts a 512-point complex frame as 32 beats of 16 parallel 12-bit samples and buffers the first half (beats 0–15). When the second half (beats 16–31) arrives, it forms the step-0 radix-2 sum and difference per lane, saturated to 12 bits. It drives the resulting add/sub lane pairs with a per-beat valid to the stage-1 block, and enforces the inter-frame spacing that the stage-1 self-timed 32-cycle window requires.

---
 rtl/fft_step1_feeder.sv | 200 ++++++++++++++++++++
 tb/tb_fft_step1_feeder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_step1_feeder.sv
// fft_step1_feeder: front end for the stage-1 butterfly.
// A 512-point complex frame arrives as 32 beats of LANES parallel samples. Beats 0..15 are
// buffered. Each of beats 16..31 is combined with the buffered beat of the same index to form
// the saturated radix-2 sum and difference per lane. After the last beat, in_ready_o is held
// low for HOLDOFF_CYC cycles so that stage-1 sees enough spacing between frames.
//
// Ports:
//   clk_i                    clock
//   rstn_i                   asynchronous active-low reset
//   in_valid_i / in_ready_o  input beat handshake (transfer when both high)
//   in_r_i / in_i_i          LANES x DATA_WIDTH signed samples, lane l at [l*DATA_WIDTH +: DATA_WIDTH]
//   dout_valid_o             output beat valid (registered)
//   dout_add_r_o/_i_o        sat(x[n] + x[n+256]), same lane packing
//   dout_sub_r_o/_i_o        sat(x[n] - x[n+256]), same lane packing
//   gap_err_o                sticky: in_valid_i dropped during emission; cleared by a frame's first beat
module fft_step1_feeder #(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned LANES       = 16,
  parameter int unsigned HALF_BEATS  = 16,
  parameter int unsigned HOLDOFF_CYC = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [LANES*DATA_WIDTH-1:0]   in_r_i,
  input  logic [LANES*DATA_WIDTH-1:0]   in_i_i,
  output logic                          dout_valid_o,
  output logic [LANES*DATA_WIDTH-1:0]   dout_add_r_o,
  output logic [LANES*DATA_WIDTH-1:0]   dout_add_i_o,
  output logic [LANES*DATA_WIDTH-1:0]   dout_sub_r_o,
  output logic [LANES*DATA_WIDTH-1:0]   dout_sub_i_o,
  output logic                          gap_err_o
);

  localparam int unsigned VecW  = LANES * DATA_WIDTH;
  localparam int unsigned CntW  = (HALF_BEATS > 1) ? $clog2(HALF_BEATS) : 1;
  localparam int unsigned HoldW = $clog2(HOLDOFF_CYC + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFill = 2'd1;
  localparam logic [1:0] StEmit = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

  localparam logic [CntW-1:0]  LastBeat = CntW'(HALF_BEATS - 1);
  localparam logic [HoldW-1:0] LastHold = HoldW'(HOLDOFF_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             gap_err_q, gap_err_d;
  logic             dout_valid_q, dout_valid_d;
  logic [VecW-1:0]  add_r_q, add_r_d, add_i_q, add_i_d;
  logic [VecW-1:0]  sub_r_q, sub_r_d, sub_i_q, sub_i_d;
  logic [VecW-1:0]  add_r_c, add_i_c, sub_r_c, sub_i_c;

  // First-half buffer; no reset needed since every entry is rewritten before it is read.
  logic [VecW-1:0]  buf_r_q [HALF_BEATS];
  logic [VecW-1:0]  buf_i_q [HALF_BEATS];

  logic accept;
  logic buf_we;
  logic [CntW-1:0] wr_idx;

  assign in_ready_o = (state_q != StHold);
  assign accept     = in_valid_i && in_ready_o;
  assign buf_we     = accept && ((state_q == StIdle) || (state_q == StFill));
  assign wr_idx     = (state_q == StIdle) ? '0 : beat_cnt_q;

  // Sign-extended add/sub at DATA_WIDTH+1 bits, clamped to the DATA_WIDTH signed range.
  function automatic logic [DATA_WIDTH-1:0] sat_op(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b,
                                                    input logic              sub);
    logic [DATA_WIDTH:0] ext_a, ext_b, res;
    ext_a = {a[DATA_WIDTH-1], a};
    ext_b = {b[DATA_WIDTH-1], b};
    res   = sub ? (ext_a - ext_b) : (ext_a + ext_b);
    // The two top bits differ only when the result left the DATA_WIDTH range.
    if (res[DATA_WIDTH] != res[DATA_WIDTH-1]) begin
      sat_op = res[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      sat_op = res[DATA_WIDTH-1:0];
    end
  endfunction

  always_comb begin
    add_r_c = '0;
    add_i_c = '0;
    sub_r_c = '0;
    sub_i_c = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      add_r_c[l*DATA_WIDTH +: DATA_WIDTH] = sat_op(buf_r_q[beat_cnt_q][l*DATA_WIDTH +: DATA_WIDTH],
                                                   in_r_i[l*DATA_WIDTH +: DATA_WIDTH], 1'b0);
      sub_r_c[l*DATA_WIDTH +: DATA_WIDTH] = sat_op(buf_r_q[beat_cnt_q][l*DATA_WIDTH +: DATA_WIDTH],
                                                   in_r_i[l*DATA_WIDTH +: DATA_WIDTH], 1'b1);
      add_i_c[l*DATA_WIDTH +: DATA_WIDTH] = sat_op(buf_i_q[beat_cnt_q][l*DATA_WIDTH +: DATA_WIDTH],
                                                   in_i_i[l*DATA_WIDTH +: DATA_WIDTH], 1'b0);
      sub_i_c[l*DATA_WIDTH +: DATA_WIDTH] = sat_op(buf_i_q[beat_cnt_q][l*DATA_WIDTH +: DATA_WIDTH],
                                                   in_i_i[l*DATA_WIDTH +: DATA_WIDTH], 1'b1);
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    gap_err_d    = gap_err_q;
    dout_valid_d = 1'b0;
    // Output data holds whenever no beat is emitted.
    add_r_d      = add_r_q;
    add_i_d      = add_i_q;
    sub_r_d      = sub_r_q;
    sub_i_d      = sub_i_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StFill;
          beat_cnt_d = CntW'(1);
          gap_err_d  = 1'b0;
        end
      end
      StFill: begin
        if (accept) begin
          if (beat_cnt_q == LastBeat) begin
            state_d    = StEmit;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CntW'(1);
          end
        end
      end
      StEmit: begin
        if (in_valid_i) begin
          dout_valid_d = 1'b1;
          add_r_d      = add_r_c;
          add_i_d      = add_i_c;
          sub_r_d      = sub_r_c;
          sub_i_d      = sub_i_c;
          if (beat_cnt_q == LastBeat) begin
            state_d    = StHold;
            beat_cnt_d = '0;
            hold_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CntW'(1);
          end
        end else begin
          gap_err_d = 1'b1;
        end
      end
      StHold: begin
        if (hold_cnt_q == LastHold) begin
          state_d    = StIdle;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= StIdle;
      beat_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      gap_err_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      add_r_q      <= '0;
      add_i_q      <= '0;
      sub_r_q      <= '0;
      sub_i_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      gap_err_q    <= gap_err_d;
      dout_valid_q <= dout_valid_d;
      add_r_q      <= add_r_d;
      add_i_q      <= add_i_d;
      sub_r_q      <= sub_r_d;
      sub_i_q      <= sub_i_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (buf_we) begin
      buf_r_q[wr_idx] <= in_r_i;
      buf_i_q[wr_idx] <= in_i_i;
    end
  end

  assign dout_valid_o = dout_valid_q;
  assign dout_add_r_o = add_r_q;
  assign dout_add_i_o = add_i_q;
  assign dout_sub_r_o = sub_r_q;
  assign dout_sub_i_o = sub_i_q;
  assign gap_err_o    = gap_err_q;

endmodule

// File: tb/tb_fft_step1_feeder.sv
// Testbench for fft_step1_feeder: table-driven saturation vectors, hand-written ramp, gap,
// back-to-back and mid-frame reset sequences, then random frames checked against a model
// that applies sat(x[n] +/- x[n+256]) directly to the frame data.
module tb_fft_step1_feeder;
  localparam int W  = 12;
  localparam int L  = 16;
  localparam int VW = W * L;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_r = '0, in_i = '0;
  logic [VW-1:0] add_r, add_i, sub_r, sub_i;
  logic          dout_valid, gap_err;

  always #5 clk = ~clk;

  fft_step1_feeder dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_r_i      (in_r),
    .in_i_i      (in_i),
    .dout_valid_o(dout_valid),
    .dout_add_r_o(add_r),
    .dout_add_i_o(add_i),
    .dout_sub_r_o(sub_r),
    .dout_sub_i_o(sub_i),
    .gap_err_o   (gap_err)
  );

  typedef struct packed {
    logic [VW-1:0] ar;
    logic [VW-1:0] ai;
    logic [VW-1:0] sr;
    logic [VW-1:0] si;
  } beat_t;

  typedef struct {
    int a_r; int b_r; int a_i; int b_i;
    int e_ar; int e_sr; int e_ai; int e_si;
  } vec_t;

  beat_t obs_q[$];
  beat_t exp_q[$];
  int    rise_q[$];
  int    run_q[$];
  int    cyc = 0;
  int    ready_run = 0;
  logic  prev_v = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    fr_r[32][16];
  int    fr_i[32][16];
  int    t_first = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: collects emitted beats, dout_valid rising cycles and in_ready-low run lengths.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_v    <= 1'b0;
      ready_run <= 0;
    end else begin
      if (dout_valid) begin
        obs_q.push_back('{ar: add_r, ai: add_i, sr: sub_r, si: sub_i});
        if (!prev_v) rise_q.push_back(cyc);
      end
      prev_v <= dout_valid;
      if (!in_ready) begin
        ready_run <= ready_run + 1;
      end else if (ready_run > 0) begin
        run_q.push_back(ready_run);
        ready_run <= 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic logic [VW-1:0] put(input logic [VW-1:0] vec, input int l, input int v);
    logic [VW-1:0] r;
    r = vec;
    r[l*W +: W] = W'(v);
    return r;
  endfunction

  task automatic fill_ramp();
    for (int b = 0; b < 32; b++)
      for (int l = 0; l < L; l++) begin
        fr_r[b][l] = 16 * b + l;
        fr_i[b][l] = -(16 * b + l);
      end
  endtask

  // Closed-form ramp results: add = 32k + 2l + 256, sub = -256 (negated for imag).
  task automatic push_ramp_exp();
    beat_t e;
    for (int k = 0; k < 16; k++) begin
      e = '0;
      for (int l = 0; l < L; l++) begin
        e.ar = put(e.ar, l, 32 * k + 2 * l + 256);
        e.sr = put(e.sr, l, -256);
        e.ai = put(e.ai, l, -(32 * k + 2 * l + 256));
        e.si = put(e.si, l, 256);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic push_model_exp();
    beat_t e;
    for (int k = 0; k < 16; k++) begin
      e = '0;
      for (int l = 0; l < L; l++) begin
        e.ar = put(e.ar, l, sat(fr_r[k][l] + fr_r[k+16][l]));
        e.sr = put(e.sr, l, sat(fr_r[k][l] - fr_r[k+16][l]));
        e.ai = put(e.ai, l, sat(fr_i[k][l] + fr_i[k+16][l]));
        e.si = put(e.si, l, sat(fr_i[k][l] - fr_i[k+16][l]));
      end
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat transferred.
  task automatic send_beat(input int b);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    for (int l = 0; l < L; l++) begin
      in_r = put(in_r, l, fr_r[b][l]);
      in_i = put(in_i, l, fr_i[b][l]);
    end
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: beat %0d not accepted within 100 cycles", b);
    end
    if (b == 0) t_first = cyc;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int gap_beat, input int gap_len);
    beat_t snap;
    for (int b = 0; b < 32; b++) begin
      if (b == gap_beat && gap_len > 0) begin
        snap = '{ar: add_r, ai: add_i, sr: sub_r, si: sub_i};
        in_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          if (gap_beat >= 16) begin
            chk("gap_valid_low", dout_valid, 0);
            chk("gap_hold_add_r", add_r, snap.ar);
            chk("gap_hold_sub_i", sub_i, snap.si);
          end
        end
      end
      send_beat(b);
      if (b == 0) chk("gap_err_clear_on_first_beat", gap_err, 0);
    end
    in_valid = 1'b0;
    chk("gap_err_after_frame", gap_err, (gap_beat >= 16 && gap_len > 0) ? 1 : 0);
  endtask

  task automatic drain();
    beat_t o, e;
    @(negedge clk);
    chk("beat_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk("add_r", o.ar, e.ar);
      chk("add_i", o.ai, e.ai);
      chk("sub_r", o.sr, e.sr);
      chk("sub_i", o.si, e.si);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  vec_t tbl[6];
  int   t0, t1, gb, gl;

  initial begin
    tbl[0] = '{2000, 100, 0, 0, 2047, 1900, 0, 0};
    tbl[1] = '{-2000, 100, 0, 0, -1900, -2048, 0, 0};
    tbl[2] = '{2047, 2047, -2048, -2048, 2047, 0, -2048, 0};
    tbl[3] = '{-2048, 2047, 0, 0, -1, -2048, 0, 0};
    tbl[4] = '{100, -2000, 0, 0, -1900, 2047, 0, 0};
    tbl[5] = '{0, 0, 1000, -1048, 0, 0, -48, 2047};

    // Reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dout_valid", dout_valid, 0);
    chk("reset_add_r", add_r, 0);
    chk("reset_add_i", add_i, 0);
    chk("reset_sub_r", sub_r, 0);
    chk("reset_sub_i", sub_i, 0);
    chk("reset_gap_err", gap_err, 0);
    rstn = 1'b1;
    #1;
    chk("ready_after_reset", in_ready, 1);
    @(negedge clk);

    // Two ramp frames back to back with in_valid held high
    rise_q.delete();
    run_q.delete();
    fill_ramp();
    push_ramp_exp();
    send_frame(-1, 0);
    t0 = t_first;
    push_ramp_exp();
    send_frame(-1, 0);
    t1 = t_first;
    idle(20);
    drain();
    chk("next_frame_accept_spacing", t1 - t0, 48);
    chk("rise_count_b2b", rise_q.size(), 2);
    if (rise_q.size() == 2) begin
      chk("first_output_latency", rise_q[0] - t0, 17);
      chk("rise_spacing", rise_q[1] - rise_q[0], 48);
    end
    chk("holdoff_runs", run_q.size(), 2);
    foreach (run_q[i]) chk("holdoff_len", run_q[i], 16);

    // Saturation vectors
    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < 32; b++)
        for (int l = 0; l < L; l++) begin
          fr_r[b][l] = (b < 16) ? tbl[v].a_r : tbl[v].b_r;
          fr_i[b][l] = (b < 16) ? tbl[v].a_i : tbl[v].b_i;
        end
      for (int k = 0; k < 16; k++) begin
        beat_t e;
        e = '0;
        for (int l = 0; l < L; l++) begin
          e.ar = put(e.ar, l, tbl[v].e_ar);
          e.sr = put(e.sr, l, tbl[v].e_sr);
          e.ai = put(e.ai, l, tbl[v].e_ai);
          e.si = put(e.si, l, tbl[v].e_si);
        end
        exp_q.push_back(e);
      end
      send_frame(-1, 0);
      idle(20);
      drain();
    end

    // One-cycle gap at emit beat k=4
    rise_q.delete();
    fill_ramp();
    push_ramp_exp();
    send_frame(20, 1);
    idle(20);
    chk("gap_err_sticky_idle", gap_err, 1);
    chk("gap_rise_count", rise_q.size(), 2);
    drain();
    push_ramp_exp();
    send_frame(-1, 0);
    idle(20);
    drain();

    // Reset during FILL at beat 9, then a clean ramp frame
    for (int b = 0; b < 32; b++)
      for (int l = 0; l < L; l++) begin
        fr_r[b][l] = int'($urandom_range(4095)) - 2048;
        fr_i[b][l] = int'($urandom_range(4095)) - 2048;
      end
    for (int b = 0; b < 9; b++) send_beat(b);
    in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    chk("midreset_valid", dout_valid, 0);
    chk("midreset_add_r", add_r, 0);
    chk("midreset_sub_i", sub_i, 0);
    chk("midreset_gap_err", gap_err, 0);
    chk("midreset_ready", in_ready, 1);
    rstn = 1'b1;
    @(negedge clk);
    fill_ramp();
    push_ramp_exp();
    send_frame(-1, 0);
    idle(20);
    drain();

    // Random frames with optional gaps and random inter-frame idle
    for (int f = 0; f < 8; f++) begin
      for (int b = 0; b < 32; b++)
        for (int l = 0; l < L; l++) begin
          fr_r[b][l] = int'($urandom_range(4095)) - 2048;
          fr_i[b][l] = int'($urandom_range(4095)) - 2048;
        end
      if ($urandom_range(1) == 1) begin
        gb = int'($urandom_range(31));
        gl = int'($urandom_range(3, 1));
      end else begin
        gb = -1;
        gl = 0;
      end
      push_model_exp();
      send_frame(gb, gl);
      idle(int'($urandom_range(5)));
    end
    idle(20);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
